ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, fed directly by the ID/EX register
//  (ex_oper/ex_reg1/ex_reg2/ex_wreg_*), driving the EX/MEM register.
//  - Single-cycle ALU/shift/MULT; HI/LO register pair.
//  - Iterative 32-step radix-2 divider for DIV/DIVU that holds the pipeline via stall_req.
// PARAMETERS
//  DIV_STEPS   32   divider iterations, one quotient bit per cycle; 32 only is legal
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  ex_oper         in   Oper_t      operation from ID/EX
//  ex_reg1         in   32  operand 1 (rs value; shamt in [4:0] for SLL/SRL/SRA)
//  ex_reg2         in   32  operand 2 (rt value or extended immediate)
//  ex_wreg_write   in   1   GPR write enable from ID/EX
//  ex_wreg_addr    in   5   GPR destination from ID/EX
//  mem_wreg_write  out  1   GPR write enable to EX/MEM
//  mem_wreg_addr   out  5   GPR destination to EX/MEM (= ex_wreg_addr)
//  mem_wdata       out  32  result to EX/MEM
//  stall_req       out  1   hold PC, IF/ID, ID/EX; EX/MEM loads a bubble
// BEHAVIOUR
//  - Result path is combinational; HI, LO and the divider FSM are the only state.
//  - rst: HI=LO=0, FSM=IDLE, counter=0. While rst=1: stall_req=0, mem_wreg_write=0.
//  - ALU results, written to mem_wdata:
//    - ORI/OR: r1|r2. AND: r1&r2. XOR: r1^r2. NOR: ~(r1|r2).
//    - ADDU: r1+r2, mod 2^32, no trap. SUBU: r1-r2, mod 2^32.
//    - SLT: signed r1<r2 -> 1 else 0. SLTU: unsigned compare, same encoding.
//    - SLL/SRL/SRA: r2 shifted by r1[4:0]; SRA is arithmetic.
//    - LUI: {r2[15:0],16'h0}.
//    - MFHI: HI. MFLO: LO.
//    - Any other oper: 0.
//  - HI/LO writes, all taking effect on the clock edge ending the EX cycle:
//    - MULT/MULTU: 64-bit signed/unsigned product; {HI,LO}=product.
//    - MTHI: HI=r1. MTLO: LO=r1.
//    - An MFHI in the next cycle sees the new value.
//  - mem_wreg_write is forced 0 for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//    For all other opers it is ex_wreg_write.
//  - Divider FSM, states IDLE -> BUSY -> DONE -> IDLE:
//    - IDLE, oper DIV/DIVU: latch |r1|, |r2| (DIV) or raw values (DIVU), plus sign flags;
//      stall_req=1; counter=0; next state BUSY.
//    - BUSY: one restoring step per cycle; stall_req=1; leave after counter reaches 31.
//      Total BUSY cycles = 32.
//    - DONE: stall_req=0; HI=remainder, LO=quotient written at the DONE edge.
//      The ID/EX register advances on that same edge; next state IDLE.
//      DONE never restarts, even though ex_oper still shows DIV.
//    - Total: 34 EX cycles for a divide (33 stalled + 1 DONE). mem_wreg_write=0 throughout.
//    - DIV sign fix: quotient negated if signs differ; remainder takes the dividend's sign.
//      0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - Divide by zero: no trap, full 34-cycle latency.
//    - DIVU: LO=0xFFFFFFFF, HI=dividend.
//    - DIV: the same magnitudes, then the sign fix.
//  - rst during BUSY: divide aborted, HI/LO=0, FSM=IDLE, stall_req=0 on the next cycle.
//  - Non-divide opers arriving in IDLE never affect the FSM.
//    In BUSY the ex_* inputs are ignored; they are held by the stall.
// STRUCTURE
//  - cpu_defines.svh additions:
//    - Oper_t members OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO.
//    - DoubleWord_t [63:0].
//    - Div_state_t {DIV_IDLE, DIV_BUSY, DIV_DONE}.
//  - Sub-module div_unit: FSM, counter, restoring datapath, sign fix.
//    Ports: clk, rst, start, is_signed, dividend, divisor -> busy, done, quot, rem.
//  - ex_stage holds the ALU mux, the multiplier, HI/LO and stall_req = start|busy.
// TESTING
//  1 ADDU r1=0xFFFFFFFF r2=2, wreg_write=1, addr=5
//    -> mem_wdata=1, mem_wreg_write=1, mem_wreg_addr=5, same cycle.
//  2 MULT r1=-3 r2=7, then MFLO, then MFHI
//    -> LO=0xFFFFFFEB, HI=0xFFFFFFFF; MULT has mem_wreg_write=0.
//  3 DIV r1=-7 r2=2, held by stall
//    -> stall_req=1 for exactly 33 cycles, then 1 DONE cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFD.
//    -> A following MFLO returns 0xFFFFFFFD.
//  4 DIVU r1=100 r2=0 -> LO=0xFFFFFFFF, HI=100, latency 34 cycles.
//  5 rst=1 at BUSY cycle 10 of a DIVU, then MFHI
//    -> stall_req=0 the next cycle, MFHI returns 0, no stale DONE.
//  6 Back-to-back DIVU 9/4 then DIVU 20/3
//    -> second divide starts only after DONE; final HI=2, LO=6, intermediate HI=1, LO=2.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types and helpers for the EX stage and its divider.
package ex_stage_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DWORD_W    = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SHAMT_W    = 5;

  typedef logic [WORD_W-1:0]  Word_t;
  typedef logic [DWORD_W-1:0] DoubleWord_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_OR,
    OP_ORI,
    OP_AND,
    OP_XOR,
    OP_NOR,
    OP_ADDU,
    OP_SUBU,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI,
    OP_MFHI,
    OP_MFLO,
    OP_MTHI,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } Oper_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } Div_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic Word_t abs_w(input Word_t x);
    return x[WORD_W-1] ? -x : x;
  endfunction

  // Operations that only touch HI/LO and never write a GPR.
  function automatic logic no_gpr_write(input Oper_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix on the way out.
module ex_stage_div_unit
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  is_signed,
  input  Word_t dividend,
  input  Word_t divisor,
  output logic  busy,
  output logic  done,
  output Word_t quot,
  output Word_t rem
);

  localparam int unsigned CNT_W = $clog2(DIV_STEPS);

  Div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  Word_t             q_r;
  Word_t             r_r;
  Word_t             d_r;
  logic              neg_q;
  logic              neg_r;

  logic [WORD_W:0]   shifted;
  logic              fits;

  // Partial remainder with the next dividend bit shifted in, and the trial compare.
  assign shifted = {r_r, q_r[WORD_W-1]};
  assign fits    = (shifted >= {1'b0, d_r});

  // FSM, step counter and restoring datapath; dividend bits leave q_r as quotient bits enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            q_r   <= is_signed ? abs_w(dividend) : dividend;
            d_r   <= is_signed ? abs_w(divisor)  : divisor;
            r_r   <= '0;
            neg_q <= is_signed & (dividend[WORD_W-1] ^ divisor[WORD_W-1]);
            neg_r <= is_signed & dividend[WORD_W-1];
            cnt   <= '0;
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          r_r <= fits ? WORD_W'(shifted - {1'b0, d_r}) : shifted[WORD_W-1:0];
          q_r <= {q_r[WORD_W-2:0], fits};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_STEPS - 1)) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

  // Quotient negated on differing signs; remainder follows the dividend's sign.
  assign quot = neg_q ? -q_r : q_r;
  assign rem  = neg_r ? -r_r : r_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU/shift result, single-cycle multiply, HI/LO, stalling divider.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  Oper_t                 ex_oper,
  input  logic [WORD_W-1:0]     ex_reg1,
  input  logic [WORD_W-1:0]     ex_reg2,
  input  logic                  ex_wreg_write,
  input  logic [REG_ADDR_W-1:0] ex_wreg_addr,
  output logic                  mem_wreg_write,
  output logic [REG_ADDR_W-1:0] mem_wreg_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  stall_req
);

  Word_t       hi;
  Word_t       lo;
  DoubleWord_t prod_s;
  DoubleWord_t prod_u;

  logic        is_div;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  Word_t       div_quot;
  Word_t       div_rem;

  assign is_div    = (ex_oper == OP_DIV) || (ex_oper == OP_DIVU);
  // Only an idle divider starts; the held DIV seen during DONE must not relaunch it.
  assign div_start = !rst && is_div && !div_busy && !div_done;
  assign stall_req = div_start || (div_busy && !rst);

  ex_stage_div_unit #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div_unit (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (ex_oper == OP_DIV),
    .dividend  (ex_reg1),
    .divisor   (ex_reg2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // Full 64-bit products from sign- or zero-extended operands.
  assign prod_s = $signed({{WORD_W{ex_reg1[WORD_W-1]}}, ex_reg1})
                * $signed({{WORD_W{ex_reg2[WORD_W-1]}}, ex_reg2});
  assign prod_u = {{WORD_W{1'b0}}, ex_reg1} * {{WORD_W{1'b0}}, ex_reg2};

  // Result mux feeding EX/MEM.
  always_comb begin
    mem_wdata = '0;
    case (ex_oper)
      OP_OR, OP_ORI: mem_wdata = ex_reg1 | ex_reg2;
      OP_AND:        mem_wdata = ex_reg1 & ex_reg2;
      OP_XOR:        mem_wdata = ex_reg1 ^ ex_reg2;
      OP_NOR:        mem_wdata = ~(ex_reg1 | ex_reg2);
      OP_ADDU:       mem_wdata = ex_reg1 + ex_reg2;
      OP_SUBU:       mem_wdata = ex_reg1 - ex_reg2;
      OP_SLT:        mem_wdata = {{(WORD_W-1){1'b0}}, ($signed(ex_reg1) < $signed(ex_reg2))};
      OP_SLTU:       mem_wdata = {{(WORD_W-1){1'b0}}, (ex_reg1 < ex_reg2)};
      OP_SLL:        mem_wdata = ex_reg2 << ex_reg1[SHAMT_W-1:0];
      OP_SRL:        mem_wdata = ex_reg2 >> ex_reg1[SHAMT_W-1:0];
      OP_SRA:        mem_wdata = $signed(ex_reg2) >>> ex_reg1[SHAMT_W-1:0];
      OP_LUI:        mem_wdata = {ex_reg2[15:0], 16'h0000};
      OP_MFHI:       mem_wdata = hi;
      OP_MFLO:       mem_wdata = lo;
      default:       mem_wdata = '0;
    endcase
  end

  // GPR write qualification; HI/LO-only operations never write back.
  assign mem_wreg_write = !rst && ex_wreg_write && !no_gpr_write(ex_oper);
  assign mem_wreg_addr  = ex_wreg_addr;

  // HI/LO updates; a finishing divide wins, and held inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_done) begin
      hi <= div_rem;
      lo <= div_quot;
    end else if (!div_busy) begin
      case (ex_oper)
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_MTHI:  hi <= ex_reg1;
        OP_MTLO:  lo <= ex_reg1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, HI/LO traffic, divide latency, reset abort.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  Oper_t       ex_oper;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic        ex_wreg_write;
  logic [4:0]  ex_wreg_addr;
  logic        mem_wreg_write;
  logic [4:0]  mem_wreg_addr;
  logic [31:0] mem_wdata;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_oper        (ex_oper),
    .ex_reg1        (ex_reg1),
    .ex_reg2        (ex_reg2),
    .ex_wreg_write  (ex_wreg_write),
    .ex_wreg_addr   (ex_wreg_addr),
    .mem_wreg_write (mem_wreg_write),
    .mem_wreg_addr  (mem_wreg_addr),
    .mem_wdata      (mem_wdata),
    .stall_req      (stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] ad);
    ex_oper       = op;
    ex_reg1       = a;
    ex_reg2       = b;
    ex_wreg_write = we;
    ex_wreg_addr  = ad;
  endtask

  task automatic alu(input string tag, input Oper_t op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b, 1'b1, 5'd3);
    @(negedge clk);
    check(tag, mem_wdata, exp);
    check({tag, "_we"}, 32'(mem_wreg_write), 32'd1);
    tick();
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(OP_MFHI, 32'h0, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    check({tag, "_mfhi"}, mem_wdata, exp_hi);
    tick();
    drive(OP_MFLO, 32'h0, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    check({tag, "_mflo"}, mem_wdata, exp_lo);
    tick();
  endtask

  // Holds the divide on ex_* while stalled, counts stall cycles, returns after the DONE edge.
  task automatic run_div(input string tag, input Oper_t op, input logic [31:0] a, input logic [31:0] b);
    int  n;
    logic wr_seen;
    n       = 0;
    wr_seen = 1'b0;
    drive(op, a, b, 1'b1, 5'd7);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      if (mem_wreg_write) wr_seen = 1'b1;
      n++;
      tick();
    end
    check({tag, "_stalls"}, 32'(n), 32'd33);
    check({tag, "_wr_busy"}, 32'(wr_seen), 32'd0);
    check({tag, "_wr_done"}, 32'(mem_wreg_write), 32'd0);
    tick();
  endtask

  initial begin
    logic bad;
    rst = 1'b1;
    drive(OP_ADDU, 32'h1, 32'h1, 1'b1, 5'd3);
    tick();
    tick();
    @(negedge clk);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_we", 32'(mem_wreg_write), 32'd0);
    tick();
    rst = 1'b0;
    read_hilo("rst", 32'h0, 32'h0);

    // ADDU wraps, same-cycle write-back controls
    drive(OP_ADDU, 32'hFFFF_FFFF, 32'h2, 1'b1, 5'd5);
    @(negedge clk);
    check("addu", mem_wdata, 32'h1);
    check("addu_we", 32'(mem_wreg_write), 32'd1);
    check("addu_addr", 32'(mem_wreg_addr), 32'd5);
    check("addu_stall", 32'(stall_req), 32'd0);
    tick();

    alu("or",    OP_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    alu("ori",   OP_ORI,  32'h0000_1200, 32'h0000_0034, 32'h0000_1234);
    alu("and",   OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    alu("xor",   OP_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0);
    alu("nor",   OP_NOR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu("subu",  OP_SUBU, 32'h0,         32'h1,         32'hFFFF_FFFF);
    alu("slt",   OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1);
    alu("slteq", OP_SLT,  32'h5,         32'h5,         32'h0);
    alu("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0);
    alu("sll",   OP_SLL,  32'd36,        32'h1,         32'h10);
    alu("srl",   OP_SRL,  32'h4,         32'h8000_0000, 32'h0800_0000);
    alu("sra",   OP_SRA,  32'h4,         32'h8000_0000, 32'hF800_0000);
    alu("sra31", OP_SRA,  32'd31,        32'h4000_0000, 32'h0);
    alu("lui",   OP_LUI,  32'h0,         32'h1234_ABCD, 32'hABCD_0000);
    alu("nop",   OP_NOP,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0);

    // MULT -3*7, then MULTU max*max
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 5'd9);
    @(negedge clk);
    check("mult_we", 32'(mem_wreg_write), 32'd0);
    tick();
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd9);
    @(negedge clk);
    check("multu_we", 32'(mem_wreg_write), 32'd0);
    tick();
    read_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    // MTHI / MTLO
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd2);
    @(negedge clk);
    check("mthi_we", 32'(mem_wreg_write), 32'd0);
    tick();
    drive(OP_MTLO, 32'h1234_5678, 32'h0, 1'b1, 5'd2);
    @(negedge clk);
    check("mtlo_we", 32'(mem_wreg_write), 32'd0);
    tick();
    read_hilo("mt", 32'hDEAD_BEEF, 32'h1234_5678);

    // Divides
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    read_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("div_ovf", 32'h0, 32'h8000_0000);
    run_div("divu_z", OP_DIVU, 32'd100, 32'd0);
    read_hilo("divu_z", 32'd100, 32'hFFFF_FFFF);
    run_div("div_z", OP_DIV, 32'hFFFF_FFF9, 32'd0);
    read_hilo("div_z", 32'hFFFF_FFF9, 32'h0000_0001);

    // Back-to-back DIVU 9/4 then 20/3
    run_div("b2b_a", OP_DIVU, 32'd9, 32'd4);
    check("b2b_mid_hi", dut.hi, 32'd1);
    check("b2b_mid_lo", dut.lo, 32'd2);
    run_div("b2b_b", OP_DIVU, 32'd20, 32'd3);
    read_hilo("b2b", 32'd2, 32'd6);

    // Reset during BUSY cycle 10 of a DIVU
    drive(OP_DIVU, 32'd50, 32'd7, 1'b1, 5'd7);
    tick();
    for (int i = 0; i < 9; i++) tick();
    @(negedge clk);
    check("abort_busy", 32'(stall_req), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_stall", 32'(stall_req), 32'd0);
    tick();
    rst = 1'b0;
    drive(OP_MFHI, 32'h0, 32'h0, 1'b1, 5'd4);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_req || mem_wdata != 32'h0) bad = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(bad), 32'd0);
    read_hilo("abort", 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
